ppu_bg_fetcher: RTL and testbench
=================================

# ppu_bg_fetcher

Background tile fetch engine for the PPU. Once per scanline it walks TILES_PER_LINE consecutive tiles. For each tile it reads the nametable byte and attribute byte from nametable VRAM, then the two pattern-plane bytes from the 8 KB CHR ROM. It hands each assembled tile record to the downstream background shifter over a valid/ready handshake. It is the sole address/enable master of the CHR ROM's synchronous 1-cycle-latency read port.

## Interface
Parameters:
- TILES_PER_LINE, 34: tiles fetched per line (32 visible + 2 prefetch); legal range 1..63.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- line_start  in  1  one-cycle pulse; starts a line fetch when idle.
- coarse_x  in  5  starting tile column; latched at line_start.
- coarse_y  in  5  tile row 0..29; latched at line_start.
- fine_y  in  3  pixel row within tile; latched at line_start.
- nt_sel  in  1  starting horizontal nametable; latched at line_start.
- pt_sel  in  1  background pattern table (0 = $0000, 1 = $1000); latched at line_start.
- vram_ena  out  1  nametable RAM read enable.
- vram_addr  out  11  nametable RAM address.
- vram_data  in  8  nametable RAM read data; valid the cycle after vram_ena.
- chr_ena  out  1  CHR ROM read enable.
- chr_addr  out  13  CHR ROM address.
- chr_data  in  8  CHR ROM read data; valid the cycle after chr_ena.
- tile_valid  out  1  tile record available.
- tile_ready  in  1  downstream accepts record.
- tile_pat_lo  out  8  pattern plane 0 byte.
- tile_pat_hi  out  8  pattern plane 1 byte.
- tile_attr  out  2  palette select for this tile.
- busy  out  1  high from the first fetch cycle through the final handshake.
- line_done  out  1  one-cycle pulse after the last tile is accepted.

## Operation
- States: IDLE, NT, AT, PLO, PHI, CAP, EMIT.
- IDLE:
  - On line_start, latch the inputs, clear the tile counter, and go to NT.
  - line_start outside IDLE is ignored.
- NT: vram_ena=1, vram_addr={nt_h, coarse_y, cx}, where cx and nt_h are the running column and nametable bit.
- AT:
  - Capture vram_data into tile_idx.
  - vram_ena=1, vram_addr={nt_h, 4'hF, coarse_y[4:2], cx[4:2]} ($3C0 attribute region).
- PLO:
  - Capture vram_data, then select bits 2*{coarse_y[1],cx[1]} +: 2 into attr_q.
  - chr_ena=1, chr_addr={pt_sel, tile_idx, 1'b0, fine_y}.
- PHI:
  - Capture chr_data into lo_q.
  - chr_ena=1, chr_addr={pt_sel, tile_idx, 1'b1, fine_y}.
- CAP: capture chr_data into hi_q, then go to EMIT.
- EMIT:
  - tile_valid=1. Outputs come from lo_q, hi_q and attr_q and stay stable until the handshake.
  - On tile_valid & tile_ready:
    - Increment cx mod 32. Toggle nt_h when cx wraps 31→0.
    - Increment the tile counter.
    - If the count reaches TILES_PER_LINE, go to IDLE and pulse line_done. Otherwise go to NT.
- vram_addr and chr_addr are 0 whenever their enable is low.
- Reset values:
  - All outputs 0; state IDLE.
  - Internal registers 0.
- Reset asserted mid-line aborts immediately. No line_done is produced, and the tile in EMIT is dropped.

## Timing
- line_start sampled at edge 0:
  - NT in cycle 1, AT in cycle 2, PLO in cycle 3, PHI in cycle 4, CAP in cycle 5.
  - tile_valid first high in cycle 6.
- With tile_ready held high, the tile period is 6 cycles.
  - A full line with TILES_PER_LINE=34 completes its last handshake in cycle 204.
  - line_done=1 and busy=0 in cycle 205.
- Backpressure only stretches EMIT. No memory access is issued while in EMIT.
- busy is high in states NT through EMIT. line_done is never high together with busy.

## Structure
- Shared ppu_pkg holds:
  - the fetch-state enum;
  - ATTR_ROW=4'hF;
  - the CHR address field widths: 1 table bit, 8 index bits, 1 plane bit, 3 fine-y bits.
- One natural sub-module, ppu_attr_select: a combinational 2-bit quadrant extract from the attribute byte, reused later by sprite-0/scroll logic.

## Test plan
- Line start with coarse_x=0, coarse_y=0, fine_y=3, pt_sel=1, nametable byte $24 → chr_addr $1243 (plane 0) in cycle 3 and $124B (plane 1) in cycle 4; tile_valid in cycle 6 with the preloaded ROM bytes.
- Attribute byte $E4 at $3C0 with coarse_y=2, coarse_x=2 → tile_attr=3; same byte with coarse_y=0, coarse_x=0 → tile_attr=0.
- coarse_x=30, nt_sel=0 → tiles 0–1 use vram_addr[10]=0, tile 2 uses cx=0 with vram_addr[10]=1.
- tile_ready low for 10 cycles in EMIT → outputs stable, no vram_ena or chr_ena pulses, next NT one cycle after acceptance.
- Full line with TILES_PER_LINE=34 and ready held high → exactly 34 handshakes, line_done in cycle 205; a line_start pulse mid-line is ignored.
- rst_n asserted in cycle 4 → all outputs 0 asynchronously; a fresh line_start after release behaves as in the first scenario.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared PPU definitions: fetch-state encoding, attribute-row constant and
// address packing helpers for the nametable RAM and the CHR ROM.
package ppu_pkg;

    typedef enum logic [2:0] {
        FS_IDLE = 3'd0,
        FS_NT   = 3'd1,
        FS_AT   = 3'd2,
        FS_PLO  = 3'd3,
        FS_PHI  = 3'd4,
        FS_CAP  = 3'd5,
        FS_EMIT = 3'd6
    } fetch_state_e;

    localparam logic [3:0] ATTR_ROW = 4'hF;

    localparam int CHR_TBL_W   = 1;
    localparam int CHR_IDX_W   = 8;
    localparam int CHR_PLANE_W = 1;
    localparam int CHR_FINE_W  = 3;
    localparam int CHR_ADDR_W  = CHR_TBL_W + CHR_IDX_W + CHR_PLANE_W + CHR_FINE_W;

    function automatic logic [10:0] nt_address(input logic nt_h, input logic [4:0] cy,
                                               input logic [4:0] cx);
        return {nt_h, cy, cx};
    endfunction

    // Each attribute byte covers a 4x4 tile block, hence the dropped low bits.
    function automatic logic [10:0] at_address(input logic nt_h, input logic [4:0] cy,
                                               input logic [4:0] cx);
        return {nt_h, ATTR_ROW, cy[4:2], cx[4:2]};
    endfunction

    function automatic logic [CHR_ADDR_W-1:0] chr_address(input logic tbl,
                                                          input logic [CHR_IDX_W-1:0] idx,
                                                          input logic plane,
                                                          input logic [CHR_FINE_W-1:0] fy);
        return {tbl, idx, plane, fy};
    endfunction

endpackage

// File: rtl/ppu_bg_fetcher_if.sv
// Tile record stream from the background fetcher to the background shifter.
interface ppu_bg_fetcher_if;
    logic       tile_valid;
    logic       tile_ready;
    logic [7:0] tile_pat_lo;
    logic [7:0] tile_pat_hi;
    logic [1:0] tile_attr;

    modport master (output tile_valid, output tile_pat_lo, output tile_pat_hi,
                    output tile_attr, input tile_ready);
    modport slave  (input tile_valid, input tile_pat_lo, input tile_pat_hi,
                    input tile_attr, output tile_ready);
endinterface

// File: rtl/ppu_attr_select.sv
// Extracts the 2-bit palette for one 2x2-tile quadrant of an attribute byte.
module ppu_attr_select (
    input  logic [7:0] attr_byte,
    input  logic       quad_y,
    input  logic       quad_x,
    output logic [1:0] attr
);

    // Quadrant mux: bottom-right in the top bits, top-left in the low bits
    always_comb begin
        attr = 2'b00;
        case ({quad_y, quad_x})
            2'b00:   attr = attr_byte[1:0];
            2'b01:   attr = attr_byte[3:2];
            2'b10:   attr = attr_byte[5:4];
            2'b11:   attr = attr_byte[7:6];
            default: attr = 2'b00;
        endcase
    end

endmodule

// File: rtl/ppu_bg_fetcher.sv
// Background tile fetch engine: per tile reads nametable and attribute bytes,
// then both CHR pattern planes, and hands the record downstream.
module ppu_bg_fetcher
    import ppu_pkg::*;
#(
    parameter int TILES_PER_LINE = 34
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  line_start,
    input  logic [4:0]            coarse_x,
    input  logic [4:0]            coarse_y,
    input  logic [2:0]            fine_y,
    input  logic                  nt_sel,
    input  logic                  pt_sel,
    output logic                  vram_ena,
    output logic [10:0]           vram_addr,
    input  logic [7:0]            vram_data,
    output logic                  chr_ena,
    output logic [CHR_ADDR_W-1:0] chr_addr,
    input  logic [7:0]            chr_data,
    ppu_bg_fetcher_if.master      tile,
    output logic                  busy,
    output logic                  line_done
);

    localparam logic [5:0] LAST_TILE = 6'(TILES_PER_LINE - 1);

    fetch_state_e          state_r;
    logic [4:0]            cx_r;
    logic [4:0]            cy_r;
    logic [2:0]            fy_r;
    logic                  nt_h_r;
    logic                  pt_r;
    logic [5:0]            count_r;
    logic [7:0]            tile_idx_r;
    logic [1:0]            attr_q_r;
    logic [7:0]            lo_q_r;
    logic                  vram_ena_r;
    logic [10:0]           vram_addr_r;
    logic                  chr_ena_r;
    logic [CHR_ADDR_W-1:0] chr_addr_r;
    logic                  tile_valid_r;
    logic [7:0]            tile_pat_lo_r;
    logic [7:0]            tile_pat_hi_r;
    logic [1:0]            tile_attr_r;
    logic                  busy_r;
    logic                  line_done_r;

    logic [1:0]            attr_s;
    logic [4:0]            cx_next_s;
    logic                  nt_h_next_s;

    ppu_attr_select u_attr_select (
        .attr_byte (vram_data),
        .quad_y    (cy_r[1]),
        .quad_x    (cx_r[1]),
        .attr      (attr_s)
    );

    // Next column and nametable after the current tile is accepted
    always_comb begin
        cx_next_s   = cx_r + 5'd1;
        nt_h_next_s = nt_h_r;
        if (cx_r == 5'd31) begin
            nt_h_next_s = ~nt_h_r;
        end else begin
            nt_h_next_s = nt_h_r;
        end
    end

    // Fetch sequencer; memory strobes and addresses are registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= FS_IDLE;
            cx_r          <= 5'd0;
            cy_r          <= 5'd0;
            fy_r          <= 3'd0;
            nt_h_r        <= 1'b0;
            pt_r          <= 1'b0;
            count_r       <= 6'd0;
            tile_idx_r    <= 8'd0;
            attr_q_r      <= 2'd0;
            lo_q_r        <= 8'd0;
            vram_ena_r    <= 1'b0;
            vram_addr_r   <= 11'd0;
            chr_ena_r     <= 1'b0;
            chr_addr_r    <= '0;
            tile_valid_r  <= 1'b0;
            tile_pat_lo_r <= 8'd0;
            tile_pat_hi_r <= 8'd0;
            tile_attr_r   <= 2'd0;
            busy_r        <= 1'b0;
            line_done_r   <= 1'b0;
        end else begin
            vram_ena_r  <= 1'b0;
            vram_addr_r <= 11'd0;
            chr_ena_r   <= 1'b0;
            chr_addr_r  <= '0;
            line_done_r <= 1'b0;
            case (state_r)
                FS_IDLE: begin
                    if (line_start) begin
                        cx_r        <= coarse_x;
                        cy_r        <= coarse_y;
                        fy_r        <= fine_y;
                        nt_h_r      <= nt_sel;
                        pt_r        <= pt_sel;
                        count_r     <= 6'd0;
                        busy_r      <= 1'b1;
                        vram_ena_r  <= 1'b1;
                        vram_addr_r <= nt_address(nt_sel, coarse_y, coarse_x);
                        state_r     <= FS_NT;
                    end
                end
                FS_NT: begin
                    vram_ena_r  <= 1'b1;
                    vram_addr_r <= at_address(nt_h_r, cy_r, cx_r);
                    state_r     <= FS_AT;
                end
                FS_AT: begin
                    tile_idx_r <= vram_data;
                    chr_ena_r  <= 1'b1;
                    chr_addr_r <= chr_address(pt_r, vram_data, 1'b0, fy_r);
                    state_r    <= FS_PLO;
                end
                FS_PLO: begin
                    attr_q_r   <= attr_s;
                    chr_ena_r  <= 1'b1;
                    chr_addr_r <= chr_address(pt_r, tile_idx_r, 1'b1, fy_r);
                    state_r    <= FS_PHI;
                end
                FS_PHI: begin
                    lo_q_r  <= chr_data;
                    state_r <= FS_CAP;
                end
                FS_CAP: begin
                    tile_pat_lo_r <= lo_q_r;
                    tile_pat_hi_r <= chr_data;
                    tile_attr_r   <= attr_q_r;
                    tile_valid_r  <= 1'b1;
                    state_r       <= FS_EMIT;
                end
                FS_EMIT: begin
                    if (tile_valid_r && tile.tile_ready) begin
                        tile_valid_r <= 1'b0;
                        cx_r         <= cx_next_s;
                        nt_h_r       <= nt_h_next_s;
                        count_r      <= count_r + 6'd1;
                        if (count_r == LAST_TILE) begin
                            busy_r      <= 1'b0;
                            line_done_r <= 1'b1;
                            state_r     <= FS_IDLE;
                        end else begin
                            vram_ena_r  <= 1'b1;
                            vram_addr_r <= nt_address(nt_h_next_s, cy_r, cx_next_s);
                            state_r     <= FS_NT;
                        end
                    end
                end
                default: begin
                    tile_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= FS_IDLE;
                end
            endcase
        end
    end

    assign vram_ena         = vram_ena_r;
    assign vram_addr        = vram_addr_r;
    assign chr_ena          = chr_ena_r;
    assign chr_addr         = chr_addr_r;
    assign tile.tile_valid  = tile_valid_r;
    assign tile.tile_pat_lo = tile_pat_lo_r;
    assign tile.tile_pat_hi = tile_pat_hi_r;
    assign tile.tile_attr   = tile_attr_r;
    assign busy             = busy_r;
    assign line_done        = line_done_r;

endmodule

// File: tb/tb_ppu_bg_fetcher.sv
// Directed self-checking bench for ppu_bg_fetcher with synchronous VRAM/CHR models.
module tb_ppu_bg_fetcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        line_start;
    logic [4:0]  coarse_x;
    logic [4:0]  coarse_y;
    logic [2:0]  fine_y;
    logic        nt_sel;
    logic        pt_sel;
    logic        vram_ena;
    logic [10:0] vram_addr;
    logic [7:0]  vram_data;
    logic        chr_ena;
    logic [12:0] chr_addr;
    logic [7:0]  chr_data;
    logic        busy;
    logic        line_done;

    int errors = 0;
    int checks = 0;
    int hs_count = 0;

    logic [7:0] vram_mem [0:2047];
    logic [7:0] chr_mem  [0:8191];

    ppu_bg_fetcher_if tif ();

    ppu_bg_fetcher #(.TILES_PER_LINE(34)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_start (line_start),
        .coarse_x   (coarse_x),
        .coarse_y   (coarse_y),
        .fine_y     (fine_y),
        .nt_sel     (nt_sel),
        .pt_sel     (pt_sel),
        .vram_ena   (vram_ena),
        .vram_addr  (vram_addr),
        .vram_data  (vram_data),
        .chr_ena    (chr_ena),
        .chr_addr   (chr_addr),
        .chr_data   (chr_data),
        .tile       (tif.master),
        .busy       (busy),
        .line_done  (line_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (vram_ena) vram_data <= vram_mem[vram_addr];
        if (chr_ena)  chr_data  <= chr_mem[chr_addr];
    end

    always @(posedge clk) begin
        if (rst_n && tif.tile_valid && tif.tile_ready) hs_count <= hs_count + 1;
    end

    task automatic start_line(input logic [4:0] cx, input logic [4:0] cy, input logic [2:0] fy,
                              input logic nt, input logic pt);
        coarse_x = cx; coarse_y = cy; fine_y = fy; nt_sel = nt; pt_sel = pt;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic finish_line();
        bit seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (line_done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL line_done_timeout: got no line_done, expected one within 400 cycles");
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if ({vram_ena, vram_addr, chr_ena, chr_addr, tif.tile_valid, tif.tile_pat_lo,
             tif.tile_pat_hi, tif.tile_attr, busy, line_done} !== 51'd0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero outputs, expected all 0");
        end
    endtask

    task automatic first_scenario(input string tag);
        start_line(5'd0, 5'd0, 3'd3, 1'b0, 1'b1);
        checks++;
        if (vram_ena !== 1'b1 || vram_addr !== 11'h000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_nt: got ena=%b addr=%h busy=%b expected 1 000 1", tag, vram_ena, vram_addr, busy);
        end
        @(negedge clk);
        checks++;
        if (vram_ena !== 1'b1 || vram_addr !== 11'h3C0) begin
            errors++;
            $display("FAIL %s_at: got ena=%b addr=%h expected 1 3c0", tag, vram_ena, vram_addr);
        end
        @(negedge clk);
        checks++;
        if (chr_ena !== 1'b1 || chr_addr !== 13'h1243 || vram_ena !== 1'b0 || vram_addr !== 11'h000) begin
            errors++;
            $display("FAIL %s_plo: got chr=%b/%h vram=%b/%h expected 1/1243 0/000", tag, chr_ena, chr_addr, vram_ena, vram_addr);
        end
        @(negedge clk);
        checks++;
        if (chr_ena !== 1'b1 || chr_addr !== 13'h124B) begin
            errors++;
            $display("FAIL %s_phi: got ena=%b addr=%h expected 1 124b", tag, chr_ena, chr_addr);
        end
        @(negedge clk);
        checks++;
        if (chr_ena !== 1'b0 || chr_addr !== 13'h0000 || tif.tile_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_cap: got chr=%b/%h valid=%b expected 0/0000 0", tag, chr_ena, chr_addr, tif.tile_valid);
        end
        @(negedge clk);
        checks++;
        if (tif.tile_valid !== 1'b1 || tif.tile_pat_lo !== 8'hA5 || tif.tile_pat_hi !== 8'h3C || tif.tile_attr !== 2'd0) begin
            errors++;
            $display("FAIL %s_emit: got v=%b lo=%h hi=%h at=%0d expected 1 a5 3c 0", tag,
                     tif.tile_valid, tif.tile_pat_lo, tif.tile_pat_hi, tif.tile_attr);
        end
        finish_line();
    endtask

    task automatic test_basic();
        first_scenario("basic");
    endtask

    task automatic test_attr();
        start_line(5'd2, 5'd2, 3'd0, 1'b0, 1'b0);
        checks++;
        if (vram_addr !== 11'h042) begin
            errors++;
            $display("FAIL attr_nt_addr: got %h expected 042", vram_addr);
        end
        @(negedge clk);
        checks++;
        if (vram_addr !== 11'h3C0) begin
            errors++;
            $display("FAIL attr_at_addr: got %h expected 3c0", vram_addr);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (tif.tile_valid !== 1'b1 || tif.tile_attr !== 2'd3) begin
            errors++;
            $display("FAIL attr_q3: got v=%b attr=%0d expected 1 3", tif.tile_valid, tif.tile_attr);
        end
        finish_line();
    endtask

    task automatic test_wrap();
        logic [10:0] exp_nt [0:2];
        logic [10:0] exp_at;
        exp_nt[0] = 11'h01E; exp_nt[1] = 11'h01F; exp_nt[2] = 11'h400; exp_at = 11'h7C0;
        start_line(5'd30, 5'd0, 3'd0, 1'b0, 1'b0);
        for (int t = 0; t < 3; t++) begin
            checks++;
            if (vram_ena !== 1'b1 || vram_addr !== exp_nt[t]) begin
                errors++;
                $display("FAIL wrap_nt%0d: got ena=%b addr=%h expected 1 %h", t, vram_ena, vram_addr, exp_nt[t]);
            end
            if (t == 2) begin
                @(negedge clk);
                checks++;
                if (vram_addr !== exp_at) begin
                    errors++;
                    $display("FAIL wrap_at2: got %h expected %h", vram_addr, exp_at);
                end
            end else begin
                repeat (6) @(negedge clk);
            end
        end
        finish_line();
    endtask

    task automatic test_backpressure();
        tif.tile_ready = 1'b0;
        start_line(5'd0, 5'd0, 3'd3, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (tif.tile_valid !== 1'b1 || tif.tile_pat_lo !== 8'hA5 || tif.tile_pat_hi !== 8'h3C ||
                tif.tile_attr !== 2'd0 || vram_ena !== 1'b0 || chr_ena !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d: got v=%b lo=%h hi=%h at=%0d ve=%b ce=%b expected 1 a5 3c 0 0 0", i,
                         tif.tile_valid, tif.tile_pat_lo, tif.tile_pat_hi, tif.tile_attr, vram_ena, chr_ena);
            end
            if (i == 9) tif.tile_ready = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (vram_ena !== 1'b1 || vram_addr !== 11'h001 || tif.tile_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_resume: got ena=%b addr=%h v=%b expected 1 001 0", vram_ena, vram_addr, tif.tile_valid);
        end
        finish_line();
    endtask

    task automatic test_full_line();
        int done_cycle = 0;
        logic busy_at_done = 1'b1;
        logic busy_204 = 1'b0;
        hs_count = 0;
        start_line(5'd0, 5'd0, 3'd0, 1'b0, 1'b0);
        for (int c = 2; c <= 300 && done_cycle == 0; c++) begin
            if (c == 50) begin
                coarse_x = 5'd17; line_start = 1'b1;
            end
            @(negedge clk);
            if (c == 50) line_start = 1'b0;
            if (c == 204) busy_204 = busy;
            if (line_done) begin
                done_cycle = c;
                busy_at_done = busy;
            end
        end
        checks++;
        if (done_cycle != 205 || busy_at_done !== 1'b0 || busy_204 !== 1'b1) begin
            errors++;
            $display("FAIL full_done_cycle: got cycle=%0d busy=%b busy204=%b expected 205 0 1", done_cycle, busy_at_done, busy_204);
        end
        checks++;
        if (hs_count != 34) begin
            errors++;
            $display("FAIL full_handshakes: got %0d expected 34", hs_count);
        end
        @(negedge clk);
        checks++;
        if (line_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_after: got done=%b busy=%b expected 0 0", line_done, busy);
        end
    endtask

    task automatic test_reset_midline();
        start_line(5'd0, 5'd0, 3'd3, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({vram_ena, vram_addr, chr_ena, chr_addr, tif.tile_valid, tif.tile_pat_lo,
             tif.tile_pat_hi, tif.tile_attr, busy, line_done} !== 51'd0) begin
            errors++;
            $display("FAIL midline_reset: got chr=%b/%h busy=%b expected all outputs 0", chr_ena, chr_addr, busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (line_done !== 1'b0 || busy !== 1'b0 || tif.tile_valid !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_%0d: got done=%b busy=%b v=%b expected 0 0 0", i, line_done, busy, tif.tile_valid);
            end
        end
        first_scenario("restart");
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) vram_mem[i] = 8'h00;
        for (int i = 0; i < 8192; i++) chr_mem[i] = 8'h00;
        vram_mem[11'h000] = 8'h24;
        vram_mem[11'h042] = 8'h24;
        vram_mem[11'h3C0] = 8'hE4;
        chr_mem[13'h1243] = 8'hA5;
        chr_mem[13'h124B] = 8'h3C;
        vram_data = 8'h00; chr_data = 8'h00;
        rst_n = 1'b0; line_start = 1'b0;
        coarse_x = 5'd0; coarse_y = 5'd0; fine_y = 3'd0; nt_sel = 1'b0; pt_sel = 1'b0;
        tif.tile_ready = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_basic();
        test_attr();
        test_wrap();
        test_backpressure();
        test_full_line();
        test_reset_midline();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
